mux_sel_ctrl: RTL

Upstream control stage for the 2:1 data selector: debounces one board push-button and toggles the selector's `sel` input on each clean press.
- Provides a 2-flop synchroniser, a counter-based debounce FSM, a one-cycle press pulse and a registered `sel` level.
- `sel` drives the selector directly; `key_flag` is available to other consumers such as LEDs or counters.

---
 rtl/mux_ctrl_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/mux_sel_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the selector control path: debounce FSM state
// encoding and the default debounce window used by the selector top level.
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    // 20 ms at 50 MHz
    localparam int CNT_MAX_DEFAULT = 999_999;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for bringing an asynchronous level into
// the local clock domain; both flops reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/mux_sel_ctrl.sv
// Push-button front end for the 2:1 selector: synchronises and debounces an
// active-low key, emits a one-cycle press pulse and toggles the sel level.
module mux_sel_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int   CNT_MAX  = CNT_MAX_DEFAULT,
    parameter logic SEL_INIT = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic sel,
    output logic key_flag,
    output logic key_busy
);

    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             key_s;

    // Sync flops reset to 1 so a key held through reset looks released first
    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(sys_clk),
        .rst(sys_rst),
        .d  (key_in),
        .q  (key_s)
    );

    // key_busy is written alongside each state change so it always matches
    // (state != IDLE) without an extra cycle of lag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            key_flag <= 1'b0;
            key_busy <= 1'b0;
            sel      <= SEL_INIT;
        end else begin
            key_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state    <= FILT_DN;
                        cnt      <= '0;
                        key_busy <= 1'b1;
                    end
                end
                FILT_DN: begin
                    if (key_s) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        key_busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= DOWN;
                        cnt      <= '0;
                        key_flag <= 1'b1;
                        sel      <= ~sel;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_s) begin
                        state <= FILT_UP;
                        cnt   <= '0;
                    end
                end
                FILT_UP: begin
                    // Release must be stable for the full window before IDLE
                    if (!key_s) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        key_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    key_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
